// File: rtl/lcd_pkg.sv
// -----------------------------------------------------------------------------
// lcd_pkg
// Shared definitions for the LCD image fetch path:
//   fetch_state_t - frame fetch FSM state encoding
//   rgb565_t      - RGB565 pixel layout as stored in the image ROM
//   SKID_DEPTH    - entries in the pixel skid buffer (also the read credit limit)
//   cnt_width()   - counter width helper that never returns zero
// -----------------------------------------------------------------------------
package lcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [4:0] r;
    logic [5:0] g;
    logic [4:0] b;
  } rgb565_t;

  localparam int SKID_DEPTH = 2;

  // $clog2(1) is 0, which would give a zero-width counter; clamp to one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_pix_skid.sv
// -----------------------------------------------------------------------------
// lcd_pix_skid
// Two-entry valid/ready buffer between the ROM read pipeline and the LCD
// writer. The head entry drives the output and only changes on a pop, so the
// output word is stable while the consumer stalls.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   in_valid/in_ready   producer handshake, in_data payload
//   out_valid/out_ready consumer handshake, out_data payload (head entry)
// -----------------------------------------------------------------------------
module lcd_pix_skid
  import lcd_pkg::*;
#(
  parameter int WIDTH = 18
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);

  logic [WIDTH-1:0] head_q;
  logic [WIDTH-1:0] tail_q;
  logic [1:0]       count_q;
  logic             push;
  logic             pop;

  // A full buffer can still accept a word in the same cycle it retires one.
  assign in_ready  = (count_q != 2'(SKID_DEPTH)) || out_ready;
  assign out_valid = (count_q != 2'd0);
  assign out_data  = head_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the two data entries are reset as well so the output word reads
      // 0 out of reset; with only two registers this costs nothing worth
      // avoiding.
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // NOTE: state registers are written with <= so every flop samples the
      // pre-edge values, independent of statement order.
      case (count_q)
        2'd0: begin
          if (push) head_q <= in_data;
        end
        2'd1: begin
          if (push && pop) head_q <= in_data;
          else if (push)   tail_q <= in_data;
        end
        default: begin
          if (pop) begin
            head_q <= tail_q;
            if (push) tail_q <= in_data;
          end
        end
      endcase
      count_q <= count_q + 2'(push) - 2'(pop);
    end
  end

endmodule

// File: rtl/lcd_img_fetch.sv
// -----------------------------------------------------------------------------
// lcd_img_fetch
// Streams one IMG_W x IMG_H frame out of a synchronous image ROM into a
// valid/ready pixel interface, tagging the first pixel of the frame (sof) and
// the last pixel of every line (eol).
//
// Reads are credit-limited: a new address is issued only while reads in
// flight plus buffered pixels (after this cycle's pop) stay below two, so the
// two-entry skid buffer can never overflow and 1 pixel/clk is sustained with
// ready held high. IMG_W*IMG_H must not exceed 2**ADDR_WIDTH.
//
// Build option:
//   LCD_IMG_FETCH_LOOP_EN  when defined, the fetcher restarts at address 0
//                          after each frame and streams until reset; when
//                          undefined, one frame is fetched per start_i.
//
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   start_i        1-cycle pulse, begins a frame (ignored unless idle)
//   busy_o         frame in progress
//   done_o         1-cycle pulse after the last pixel handshake
//   rom_addr_o     image ROM word address (registered, held between issues)
//   rom_data_i     ROM read data, valid one clock after its address
//   pix_data_o     output pixel, pix_valid_o / pix_ready_i handshake
//   pix_sof_o      first pixel of frame, pix_eol_o last pixel of line
// -----------------------------------------------------------------------------
module lcd_img_fetch
  import lcd_pkg::*;
#(
  parameter int ADDR_WIDTH = 17,
  parameter int DATA_WIDTH = 16,
  parameter int IMG_W      = 320,
  parameter int IMG_H      = 240
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] rom_addr_o,
  input  logic [DATA_WIDTH-1:0] rom_data_i,
  output logic [DATA_WIDTH-1:0] pix_data_o,
  output logic                  pix_valid_o,
  input  logic                  pix_ready_i,
  output logic                  pix_sof_o,
  output logic                  pix_eol_o
);

  localparam int PIX_TOTAL = IMG_W * IMG_H;
  localparam int COL_W     = cnt_width(IMG_W);
  localparam int LINE_W    = cnt_width(IMG_H);
  localparam int SKID_W    = DATA_WIDTH + 2;

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PIX_TOTAL - 1);
  localparam logic [COL_W-1:0]      LAST_COL  = COL_W'(IMG_W - 1);
  localparam logic [LINE_W-1:0]     LAST_LINE = LINE_W'(IMG_H - 1);

  fetch_state_t          state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [COL_W-1:0]      col_q;
  logic [LINE_W-1:0]     line_q;
  logic [1:0]            occ_q;       // reads in flight + pixels buffered
  logic                  rd_pend_q;   // ROM data for the last issue arrives now
  logic                  pend_sof_q;
  logic                  pend_eol_q;
  logic                  done_q;

  logic                  issue;
  logic                  last_issue;
  logic                  last_hs;
  logic                  pop;

  logic                  skid_in_ready;
  logic                  skid_out_valid;
  logic [SKID_W-1:0]     skid_out_data;

  assign pop = skid_out_valid && pix_ready_i;

  // Counting this cycle's pop as free credit is what lets a full pipeline keep
  // issuing back-to-back with ready held high.
  assign issue      = (state_q == ST_FETCH) && ((occ_q < 2'(SKID_DEPTH)) || pop);
  assign last_issue = issue && (addr_q == LAST_ADDR);
  // In DRAIN nothing new is issued, so occ_q counts the pixels still owed; the
  // pop that empties it is the last pixel of the frame.
  assign last_hs    = (state_q == ST_DRAIN) && pop && (occ_q == 2'd1);

  // Frame FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE:  if (start_i)    state_q <= ST_FETCH;
        ST_FETCH: if (last_issue) state_q <= ST_DRAIN;
        ST_DRAIN: begin
`ifdef LCD_IMG_FETCH_LOOP_EN
          if (last_hs) state_q <= ST_FETCH;
`else
          if (last_hs) state_q <= ST_IDLE;
`endif
        end
        default:  state_q <= ST_IDLE;
      endcase
    end
  end

  // Address and raster position of the next read. The address holds on the
  // final issue so rom_addr_o stays stable through DRAIN, and is cleared when
  // the frame retires so the next frame (or loop pass) begins at 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
      col_q  <= '0;
      line_q <= '0;
    end else if (last_hs || ((state_q == ST_IDLE) && start_i)) begin
      addr_q <= '0;
      col_q  <= '0;
      line_q <= '0;
    end else if (issue) begin
      if (!last_issue) addr_q <= addr_q + 1'b1;
      if (col_q == LAST_COL) begin
        col_q  <= '0;
        line_q <= (line_q == LAST_LINE) ? '0 : line_q + 1'b1;
      end else begin
        col_q <= col_q + 1'b1;
      end
    end
  end

  // Read tracking: flags ride along with each issue so they meet their ROM
  // word at the capture edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q      <= '0;
      rd_pend_q  <= 1'b0;
      pend_sof_q <= 1'b0;
      pend_eol_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      occ_q      <= occ_q + 2'(issue) - 2'(pop);
      rd_pend_q  <= issue;
      pend_sof_q <= issue && (col_q == '0) && (line_q == '0);
      pend_eol_q <= issue && (col_q == LAST_COL);
      done_q     <= last_hs;
    end
  end

  lcd_pix_skid #(
    .WIDTH(SKID_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rd_pend_q),
    .in_ready (skid_in_ready),
    .in_data  ({pend_sof_q, pend_eol_q, rom_data_i}),
    .out_valid(skid_out_valid),
    .out_ready(pix_ready_i),
    .out_data (skid_out_data)
  );

  // The credit limit guarantees a tracked read always finds room.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    rd_pend_q |-> skid_in_ready);

  assign rom_addr_o  = addr_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = done_q;
  assign pix_valid_o = skid_out_valid;
  assign pix_data_o  = skid_out_data[DATA_WIDTH-1:0];
  // Flags are qualified by valid so a stale head entry never shows sof/eol.
  assign pix_sof_o   = skid_out_valid && skid_out_data[SKID_W-1];
  assign pix_eol_o   = skid_out_valid && skid_out_data[SKID_W-2];

endmodule
